console_tx_fifo: RTL and testbench

CONSOLE_TX_FIFO -- requirements
Module: console_tx_fifo

---
 rtl/console_pkg.sv | 14 +
 rtl/console_tx_fifo_if.sv | 34 +++
 rtl/console_fifo_mem.sv | 25 ++
 rtl/console_tx_fifo.sv | 108 ++++++++++
 tb/tb_console_tx_fifo.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/console_pkg.sv
// Shared constants and drain-FSM encoding for the console TX FIFO.
// Imported by the FIFO top, its storage and its interface.
package console_pkg;

  localparam int CONSOLE_FIFO_DEPTH = 16;
  localparam int CONSOLE_BYTE_W     = 8;
  localparam int UART_REG_W         = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/console_tx_fifo_if.sv
// CPU/UART-side signal bundle of the console TX FIFO.
// master drives the FIFO; slave is the FIFO's view.
interface console_tx_fifo_if
  import console_pkg::*;
#(
  parameter int AW = 4
);

  logic                      push_we;
  logic [CONSOLE_BYTE_W-1:0] push_data;
  logic                      flush;
  logic                      full;
  logic                      empty;
  logic [AW:0]               level;
  logic                      overflow;
  logic                      uart_dat_we;
  logic [UART_REG_W-1:0]     uart_dat_di;
  logic                      uart_dat_wait;

  modport master (
    output push_we, push_data, flush,
    output uart_dat_wait,
    input  full, empty, level, overflow,
    input  uart_dat_we, uart_dat_di
  );

  modport slave (
    input  push_we, push_data, flush,
    input  uart_dat_wait,
    output full, empty, level, overflow,
    output uart_dat_we, uart_dat_di
  );

endinterface

// File: rtl/console_fifo_mem.sv
// Byte storage for the console TX FIFO: one write, one read port.
// No reset on the array so it maps onto RAM.
module console_fifo_mem
  import console_pkg::*;
#(
  parameter int DEPTH = CONSOLE_FIFO_DEPTH,
  parameter int AW    = 4
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [AW-1:0]             waddr,
  input  logic [CONSOLE_BYTE_W-1:0] wdata,
  input  logic [AW-1:0]             raddr,
  output logic [CONSOLE_BYTE_W-1:0] rdata
);

  logic [CONSOLE_BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/console_tx_fifo.sv
// Console TX FIFO: queues CPU bytes and drains them into simpleuart.
// Level counts the in-flight byte until the UART accepts it.
module console_tx_fifo
  import console_pkg::*;
#(
  parameter int DEPTH = CONSOLE_FIFO_DEPTH,
  parameter int AW    = 4
) (
  input  logic                      CLK,
  input  logic                      resetn,
  input  logic                      push_we,
  input  logic [CONSOLE_BYTE_W-1:0] push_data,
  input  logic                      flush,
  output logic                      full,
  output logic                      empty,
  output logic [AW:0]               level,
  output logic                      overflow,
  output logic                      uart_dat_we,
  output logic [UART_REG_W-1:0]     uart_dat_di,
  input  logic                      uart_dat_wait
);

  localparam int PAD_W = UART_REG_W - CONSOLE_BYTE_W;

  tx_state_e                 state_q, state_d;
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [CONSOLE_BYTE_W-1:0] head;
  logic                      push_ok, pop;
  logic                      we_d;
  logic [UART_REG_W-1:0]     di_d;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push_we & ~full & ~flush;

  console_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (CLK),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (push_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_comb begin
    state_d = state_q;
    we_d    = uart_dat_we;
    di_d    = uart_dat_di;
    pop     = 1'b0;
    if (flush) begin
      state_d = IDLE;
      we_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (!empty) begin
          state_d = SEND;
          we_d    = 1'b1;
          di_d    = {{PAD_W{1'b0}}, head};
        end
        SEND: if (!uart_dat_wait) begin
          pop     = 1'b1;
          we_d    = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      uart_dat_we <= 1'b0;
      uart_dat_di <= '0;
    end else begin
      state_q     <= state_d;
      uart_dat_we <= we_d;
      uart_dat_di <= di_d;
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // a pop on the same cycle never makes room for a push at full
      if (push_we && full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_console_tx_fifo.sv
// Scoreboard bench for console_tx_fifo: driver queues accepted
// bytes, a negedge monitor pops and checks every UART acceptance.
module tb_console_tx_fifo;
  import console_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic CLK = 1'b0;
  logic resetn = 1'b0;
  always #5 CLK = ~CLK;

  console_tx_fifo_if #(.AW(AW)) bus ();

  console_tx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .CLK           (CLK),
    .resetn        (resetn),
    .push_we       (bus.push_we),
    .push_data     (bus.push_data),
    .flush         (bus.flush),
    .full          (bus.full),
    .empty         (bus.empty),
    .level         (bus.level),
    .overflow      (bus.overflow),
    .uart_dat_we   (bus.uart_dat_we),
    .uart_dat_di   (bus.uart_dat_di),
    .uart_dat_wait (bus.uart_dat_wait)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  int pend = 0;
  bit last_acc = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // monitor: decisions here refer to the upcoming rising edge
  always @(negedge CLK) begin
    int lvl;
    logic [7:0] b;
    if (resetn) begin
      lvl = exp_q.size() - pend;
      if (!bus.flush) begin
        check("level", 32'(bus.level), 32'(lvl));
        check("full", 32'(bus.full), 32'(lvl == DEPTH));
        check("empty", 32'(bus.empty), 32'(lvl == 0));
      end
      if (last_acc) check("we_gap", 32'(bus.uart_dat_we), 0);
      last_acc = 1'b0;
      if (bus.uart_dat_we && !bus.uart_dat_wait && !bus.flush) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", bus.uart_dat_di, 32'hFFFF_FFFF);
        end else begin
          b = exp_q.pop_front();
          check("byte", bus.uart_dat_di, {24'h0, b});
        end
        last_acc = 1'b1;
      end
      pend = 0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.push_we = 1'b1;
    bus.push_data = b;
    if (!bus.flush && exp_q.size() < DEPTH) begin
      exp_q.push_back(b);
      pend = 1;
    end
    tick();
    bus.push_we = 1'b0;
  endtask

  task automatic wait_we();
    int n = 0;
    while (!bus.uart_dat_we && n < 50) begin
      tick();
      n++;
    end
    check("wait_we_timeout", 32'(bus.uart_dat_we), 1);
  endtask

  task automatic drain();
    int n = 0;
    bus.uart_dat_wait = 1'b0;
    while ((exp_q.size() != 0 || !bus.empty
            || bus.uart_dat_we) && n < 400) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(n < 400), 1);
  endtask

  initial begin
    bus.push_we = 1'b0;
    bus.push_data = 8'h00;
    bus.flush = 1'b0;
    bus.uart_dat_wait = 1'b0;
    repeat (3) tick();
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_level", 32'(bus.level), 0);
    check("rst_we", 32'(bus.uart_dat_we), 0);
    check("rst_di", bus.uart_dat_di, 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    resetn = 1'b1;
    tick();

    // single byte latency
    push(8'h41);
    check("lat_e", 32'(bus.uart_dat_we), 0);
    tick();
    check("lat_we", 32'(bus.uart_dat_we), 1);
    check("lat_di", bus.uart_dat_di, 32'h41);
    tick();
    check("single_we_low", 32'(bus.uart_dat_we), 0);
    check("single_empty", 32'(bus.empty), 1);

    // backpressure
    bus.uart_dat_wait = 1'b1;
    push(8'h48);
    push(8'h49);
    wait_we();
    for (int i = 0; i < 100; i++) begin
      tick();
      check("bp_we", 32'(bus.uart_dat_we), 1);
      check("bp_di", bus.uart_dat_di, 32'h48);
    end
    drain();

    // flush mid-SEND with a simultaneous push
    bus.uart_dat_wait = 1'b1;
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    wait_we();
    bus.flush = 1'b1;
    bus.push_we = 1'b1;
    bus.push_data = 8'h77;
    exp_q.delete();
    pend = 0;
    tick();
    bus.flush = 1'b0;
    bus.push_we = 1'b0;
    check("flush_we", 32'(bus.uart_dat_we), 0);
    check("flush_level", 32'(bus.level), 0);
    check("flush_empty", 32'(bus.empty), 1);
    check("flush_ovf", 32'(bus.overflow), 0);
    bus.uart_dat_wait = 1'b0;
    push(8'h55);
    drain();

    // full and overflow
    bus.uart_dat_wait = 1'b1;
    for (int i = 0; i <= 16; i++) push(8'(i));
    check("ovf_full", 32'(bus.full), 1);
    check("ovf_level", 32'(bus.level), 16);
    check("ovf_set", 32'(bus.overflow), 1);
    drain();
    check("ovf_sticky", 32'(bus.overflow), 1);

    // randomized stream with wait toggling
    for (int i = 0; i < 40; i++) begin
      bus.uart_dat_wait = 1'($urandom_range(0, 1));
      push(8'($urandom));
      for (int k = 0; k < 2; k++) begin
        bus.uart_dat_wait = 1'($urandom_range(0, 1));
        tick();
      end
    end
    drain();

    // async reset in the middle of SEND
    bus.uart_dat_wait = 1'b1;
    push(8'h5A);
    wait_we();
    #2;
    resetn = 1'b0;
    #1;
    check("arst_we", 32'(bus.uart_dat_we), 0);
    check("arst_level", 32'(bus.level), 0);
    check("arst_empty", 32'(bus.empty), 1);
    check("arst_ovf", 32'(bus.overflow), 0);
    check("arst_di", bus.uart_dat_di, 0);
    exp_q.delete();
    pend = 0;
    last_acc = 1'b0;
    tick();
    resetn = 1'b1;
    bus.uart_dat_wait = 1'b0;
    push(8'h33);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
